// File: rtl/conv_kxk_acc_if.sv
// Stream bundle for conv_kxk_acc: window/weight beats in, requantised results out.
// master = producer/consumer side, slave = the MAC.
interface conv_kxk_acc_if #(
    parameter int K    = 3,
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int ACCW = 32,
    parameter int OUTW = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [K*K*DW-1:0]      data_in;
    logic [K*K*WW-1:0]      weight_in;
    logic signed [ACCW-1:0] bias;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [OUTW-1:0] data_out;
    logic                   out_sat;

    modport master (
        output in_valid, in_first, in_last, data_in, weight_in, bias, out_ready,
        input  in_ready, out_valid, data_out, out_sat
    );

    modport slave (
        input  in_valid, in_first, in_last, data_in, weight_in, bias, out_ready,
        output in_ready, out_valid, data_out, out_sat
    );
endinterface

// File: rtl/conv_kxk_acc.sv
// KxK conv MAC: products, adder tree, channel accumulator, round/shift/saturate.
// Optional ReLU after saturation when CONV_RELU_EN is defined.
module conv_kxk_acc #(
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int ACCW  = 32,
    parameter int OUTW  = 16,
    parameter int SHIFT = 0
) (
    input logic           clk,
    input logic           rst_n,
    conv_kxk_acc_if.slave bus
);
    localparam int N  = K * K;
    localparam int PW = DW + WW;

    localparam logic signed [ACCW:0] ONE  = 1;
    localparam logic signed [ACCW:0] RND  = (ONE << SHIFT) >> 1;
    localparam logic signed [ACCW:0] OMAX =
        {{(ACCW-OUTW+2){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [ACCW:0] OMIN =
        {{(ACCW-OUTW+2){1'b1}}, {(OUTW-1){1'b0}}};

    typedef struct packed {
        logic                   valid;
        logic                   first;
        logic                   last;
        logic signed [ACCW-1:0] bias;
    } ctl_t;

    ctl_t                   s1;
    ctl_t                   s2;
    logic signed [PW-1:0]   s1_prod [N];
    logic signed [ACCW-1:0] s2_sum;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_n;
    logic signed [ACCW:0]   acc_x;
    logic signed [ACCW:0]   r;
    logic signed [OUTW-1:0] q;
    logic                   sat;
    logic                   advance;

    // A held, unconsumed result freezes the whole pipe.
    assign advance      = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = advance;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            sum = sum + ACCW'(s1_prod[i]);
    end

    // One extra bit keeps the rounding add from wrapping.
    always_comb begin
        acc_n = s2.first ? s2.bias + s2_sum : acc + s2_sum;
        acc_x = (ACCW+1)'(acc_n);
        r     = (acc_x + RND) >>> SHIFT;
        q     = r[OUTW-1:0];
        sat   = 1'b0;
        if (r > OMAX) begin
            q   = OMAX[OUTW-1:0];
            sat = 1'b1;
        end else if (r < OMIN) begin
            q   = OMIN[OUTW-1:0];
            sat = 1'b1;
        end
`ifdef CONV_RELU_EN
        if (q[OUTW-1])
            q = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= '0;
            s2            <= '0;
            s2_sum        <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.out_sat   <= 1'b0;
            for (int i = 0; i < N; i++)
                s1_prod[i] <= '0;
        end else if (advance) begin
            s1.valid <= bus.in_valid;
            s1.first <= bus.in_first;
            s1.last  <= bus.in_last;
            s1.bias  <= bus.bias;
            for (int i = 0; i < N; i++)
                s1_prod[i] <= PW'($signed(bus.data_in[i*DW +: DW]))
                            * PW'($signed(bus.weight_in[i*WW +: WW]));
            s2     <= s1;
            s2_sum <= sum;
            if (s2.valid)
                acc <= acc_n;
            bus.out_valid <= s2.valid && s2.last;
            if (s2.valid && s2.last) begin
                bus.data_out <= q;
                bus.out_sat  <= sat;
            end
        end
    end
endmodule

// File: tb/tb_conv_kxk_acc.sv
// Bench for conv_kxk_acc: integer model + scoreboard, directed literal checks.
// Second instance with SHIFT=2 covers rounding.
module tb_conv_kxk_acc;
    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    conv_kxk_acc_if #(.K(3), .DW(8), .WW(8), .ACCW(32), .OUTW(16)) bus ();
    conv_kxk_acc_if #(.K(3), .DW(8), .WW(8), .ACCW(32), .OUTW(16)) bus2 ();

    conv_kxk_acc #(.K(3), .DW(8), .WW(8), .ACCW(32), .OUTW(16), .SHIFT(0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    conv_kxk_acc #(.K(3), .DW(8), .WW(8), .ACCW(32), .OUTW(16), .SHIFT(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [16:0] expq [$];
    int          macc;
    logic        hold;
    logic [16:0] hold_v;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] vec(int base, int step);
        logic [71:0] v;
        int          e;
        for (int i = 0; i < 9; i++) begin
            e = base + step * i;
            v[i*8 +: 8] = e[7:0];
        end
        return v;
    endfunction

    function automatic int dot(logic [71:0] d, logic [71:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++)
            s = s + int'($signed(d[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
        return s;
    endfunction

    // {sat, data}: round half up, floor shift, clip to 16 bits
    function automatic logic [16:0] requant(int a, int sh);
        longint v;
        v = longint'(a);
        if (sh > 0)
            v = v + (64'sd1 <<< (sh - 1));
        v = v >>> sh;
        if (v > 32767)
            return {1'b1, 16'h7fff};
`ifdef CONV_RELU_EN
        if (v < -32768)
            return {1'b1, 16'h0000};
        if (v < 0)
            return {1'b0, 16'h0000};
`else
        if (v < -32768)
            return {1'b1, 16'h8000};
`endif
        return {1'b0, v[15:0]};
    endfunction

    task automatic beat(logic [71:0] d, logic [71:0] w, int b, bit f, bit l);
        bit ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_first  = f;
        bus.in_last   = l;
        bus.data_in   = d;
        bus.weight_in = w;
        bus.bias      = b;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL accept: in_ready stuck at 0, required 1");
        end else begin
            if (f)
                macc = b + dot(d, w);
            else
                macc = macc + dot(d, w);
            if (l)
                expq.push_back(requant(macc, 0));
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(string nm, logic [15:0] ed, bit es, int lat);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.out_valid && c < 20);
        if (!bus.out_valid) begin
            nvec++;
            nerr++;
            $display("FAIL %s: out_valid 0 after %0d cycles, required 1", nm, c);
        end else begin
            chk(nm, {bus.out_sat, bus.data_out}, {es, ed});
            if (lat > 0)
                chk({nm, "_lat"}, c, lat);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out", {bus.out_valid, bus.out_sat, bus.data_out}, 0);
            hold = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (hold)
                chk("hold", {bus.out_valid, bus.out_sat, bus.data_out}, {1'b1, hold_v});
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL extra: unexpected output %0h, required none",
                             {bus.out_sat, bus.data_out});
                end else begin
                    chk("score", {bus.out_sat, bus.data_out}, expq.pop_front());
                end
            end
            hold   = bus.out_valid && !bus.out_ready;
            hold_v = {bus.out_sat, bus.data_out};
        end
    end

    int acc2 [5] = '{6, -6, 5, 2, -2};
    int exp2 [5] = '{2, -1, 1, 1, 0};

    initial begin
        rst_n          = 1'b0;
        macc           = 0;
        hold           = 1'b0;
        hold_v         = '0;
        bus.in_valid   = 1'b0;
        bus.in_first   = 1'b0;
        bus.in_last    = 1'b0;
        bus.data_in    = '0;
        bus.weight_in  = '0;
        bus.bias       = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_first  = 1'b1;
        bus2.in_last   = 1'b1;
        bus2.data_in   = '0;
        bus2.weight_in = '0;
        bus2.bias      = '0;
        bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        beat(vec(1, 0), vec(1, 0), 0, 1, 1);
        expect_out("single", 16'd9, 1'b0, 3);

        beat(vec(1, 0), vec(1, 0), 5, 1, 0);
        beat(vec(1, 0), vec(1, 0), 0, 0, 0);
        beat(vec(1, 0), vec(1, 0), 0, 0, 1);
        expect_out("three_ch", 16'd32, 1'b0, 0);

        beat(vec(1, 0), vec(1, 0), 0, 0, 1);
        expect_out("no_first", 16'd41, 1'b0, 0);

        beat(vec(1, 0), vec(1, 0), 100, 1, 0);
        beat(vec(1, 0), vec(1, 0), 0, 1, 1);
        expect_out("refirst", 16'd9, 1'b0, 0);

        beat(vec(-4, 1), vec(-10, 3), -1000, 1, 1);
        expect_out("mixed", 16'hfccc, 1'b0, 0);

        beat(vec(127, 0), vec(127, 0), 0, 1, 1);
        expect_out("sat_pos", 16'h7fff, 1'b1, 0);

        beat(vec(-128, 0), vec(127, 0), 0, 1, 1);
`ifdef CONV_RELU_EN
        expect_out("sat_neg", 16'h0000, 1'b1, 0);
`else
        expect_out("sat_neg", 16'h8000, 1'b1, 0);
`endif

        fork
            begin
                for (int i = 0; i < 8; i++)
                    beat(vec(i + 1, 0), vec(-2, 1), i * 10, 1, 1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1 chk("stream_drain", expq.size(), 0);

        beat(vec(1, 0), vec(1, 0), 0, 1, 1);
        beat(vec(2, 0), vec(1, 0), 0, 1, 0);
        beat(vec(2, 0), vec(1, 0), 0, 0, 0);
        rst_n = 1'b0;
        expq.delete();
        macc = 0;
        #1 chk("rst_async", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        beat(vec(1, 0), vec(1, 0), 0, 1, 1);
        expect_out("after_rst", 16'd9, 1'b0, 3);

        for (int i = 0; i < 5; i++) begin
            int c;
            bus2.bias     = acc2[i];
            bus2.in_valid = 1'b1;
            @(posedge clk);
            #1 bus2.in_valid = 1'b0;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!bus2.out_valid && c < 20);
            chk("shift2", {bus2.out_valid, bus2.out_sat, bus2.data_out},
                {2'b10, 16'(exp2[i])});
            @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1 chk("final_drain", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
